// File: rtl/if_fetch_buf_pkg.sv
// Shared fetch-buffer sizing for IF and ID, plus fixed inst-SRAM request attributes.
package if_fetch_buf_pkg;

  localparam int FETCH_BUF_DEPTH    = 4;
  localparam int FETCH_ADDR_W       = 32;
  localparam int FETCH_DATA_W       = 32;
  localparam int IF_TO_ID_BUS_WIDTH = FETCH_ADDR_W + FETCH_DATA_W;

  localparam logic       SRAM_WR_READ   = 1'b0;
  localparam logic [1:0] SRAM_SIZE_WORD = 2'b10;

endpackage

// File: rtl/if_fetch_buf.sv
// In-order fetch buffer between IF and a split-transaction inst SRAM; up to DEPTH fetches in flight.
// Response lands in cycle N, reaches ID in N+1; flush kills entries and owes-drops late responses.
module if_fetch_buf
  import if_fetch_buf_pkg::*;
#(
  parameter  int DEPTH  = FETCH_BUF_DEPTH,
  parameter  int ADDR_W = FETCH_ADDR_W,
  parameter  int DATA_W = FETCH_DATA_W,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_req_valid,
  input  logic [ADDR_W-1:0] pc_req_addr,
  output logic              pc_req_ready,
  input  logic              flush,
  output logic              inst_sram_req,
  output logic              inst_sram_wr,
  output logic [1:0]        inst_sram_size,
  output logic [ADDR_W-1:0] inst_sram_addr,
  input  logic              inst_sram_addr_ok,
  input  logic              inst_sram_data_ok,
  input  logic [DATA_W-1:0] inst_sram_rdata,
  input  logic              id_allow_in,
  output logic              if_to_id_valid,
  output logic [ADDR_W-1:0] if_to_id_pc,
  output logic [DATA_W-1:0] if_to_id_inst
);

  localparam logic [CNT_W:0] FULL_LVL = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [DATA_W-1:0] inst_q [DEPTH];
  logic [DEPTH-1:0]  filled_q, filled_d;
  logic [PTR_W-1:0]  head_q, head_d, fill_q, fill_d, tail_q, tail_d;
  logic [CNT_W-1:0]  alloc_cnt_q, alloc_cnt_d, cancel_cnt_q, cancel_cnt_d;
  logic [CNT_W-1:0]  filled_cnt, unfilled;
  logic [CNT_W:0]    inflight;
  logic              alloc, fill, drop, pop;

  always_comb begin
    filled_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      filled_cnt = filled_cnt + CNT_W'(filled_q[i]);
    end
  end

  assign unfilled = alloc_cnt_q - filled_cnt;
  // Cancelled fetches still occupy SRAM slots, so they count toward fullness.
  assign inflight = {1'b0, alloc_cnt_q} + {1'b0, cancel_cnt_q};

  assign inst_sram_req  = ~reset & pc_req_valid & ~flush & (inflight < FULL_LVL);
  assign inst_sram_wr   = SRAM_WR_READ;
  assign inst_sram_size = SRAM_SIZE_WORD;
  assign inst_sram_addr = pc_req_addr;
  assign pc_req_ready   = inst_sram_req & inst_sram_addr_ok;

  assign alloc = pc_req_ready;
  assign drop  = inst_sram_data_ok & (cancel_cnt_q != '0);
  assign fill  = inst_sram_data_ok & (cancel_cnt_q == '0) & (unfilled != '0);

  assign if_to_id_valid = ~reset & ~flush & filled_q[head_q];
  assign if_to_id_pc    = pc_q[head_q];
  assign if_to_id_inst  = inst_q[head_q];
  assign pop            = if_to_id_valid & id_allow_in;

  always_comb begin
    head_d       = head_q;
    fill_d       = fill_q;
    tail_d       = tail_q;
    filled_d     = filled_q;
    alloc_cnt_d  = alloc_cnt_q;
    cancel_cnt_d = cancel_cnt_q;
    if (flush) begin
      // Every unfilled fetch, minus one answered this very cycle, becomes an owed drop.
      head_d       = '0;
      fill_d       = '0;
      tail_d       = '0;
      filled_d     = '0;
      alloc_cnt_d  = '0;
      cancel_cnt_d = cancel_cnt_q - CNT_W'(drop) + unfilled - CNT_W'(fill);
    end else begin
      if (alloc) tail_d = tail_q + PTR_W'(1);
      if (fill) begin
        fill_d           = fill_q + PTR_W'(1);
        filled_d[fill_q] = 1'b1;
      end
      if (pop) begin
        head_d           = head_q + PTR_W'(1);
        filled_d[head_q] = 1'b0;
      end
      if (drop) cancel_cnt_d = cancel_cnt_q - CNT_W'(1);
      alloc_cnt_d = alloc_cnt_q + CNT_W'(alloc) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q       <= '0;
      fill_q       <= '0;
      tail_q       <= '0;
      filled_q     <= '0;
      alloc_cnt_q  <= '0;
      cancel_cnt_q <= '0;
    end else begin
      head_q       <= head_d;
      fill_q       <= fill_d;
      tail_q       <= tail_d;
      filled_q     <= filled_d;
      alloc_cnt_q  <= alloc_cnt_d;
      cancel_cnt_q <= cancel_cnt_d;
    end
  end

  // Payload storage needs no reset; the filled bits qualify it.
  always_ff @(posedge clk) begin
    if (alloc) pc_q[tail_q] <= pc_req_addr;
    if (fill)  inst_q[fill_q] <= inst_sram_rdata;
  end

endmodule

// File: tb/tb_if_fetch_buf.sv
// Queue-based reference model of the fetch buffer, directed scenarios plus randomized traffic.
module tb_if_fetch_buf;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pc_req_valid = 1'b0;
  logic [31:0] pc_req_addr = '0;
  logic        pc_req_ready;
  logic        flush = 1'b0;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        addr_ok = 1'b0;
  logic        data_ok = 1'b0;
  logic [31:0] rdata = '0;
  logic        id_allow_in = 1'b0;
  logic        if_to_id_valid;
  logic [31:0] if_to_id_pc, if_to_id_inst;

  if_fetch_buf #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .pc_req_valid(pc_req_valid), .pc_req_addr(pc_req_addr), .pc_req_ready(pc_req_ready),
    .flush(flush),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_addr(inst_sram_addr), .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok),
    .inst_sram_rdata(rdata),
    .id_allow_in(id_allow_in), .if_to_id_valid(if_to_id_valid),
    .if_to_id_pc(if_to_id_pc), .if_to_id_inst(if_to_id_inst)
  );

  always #5 clk = ~clk;

  // Reference model: delivered-ready entries, pcs awaiting data, owed drops.
  ent_t        rdy_q[$];
  logic [31:0] wait_q[$];
  int          cancel_m = 0;
  // SRAM side: accepted requests in order, each with its eventual response data.
  ent_t        sram_q[$];

  logic [31:0] dlog[$];
  int          dcyc[$];
  int          acyc[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  bit          want_dok = 0;
  bit          allow_spur = 0;
  bit          last_acc, last_vld, last_req;
  logic [31:0] last_pc;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'd7) ^ 32'h5a5a_3c3c;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    logic e_req, e_vld;
    ent_t e;
    data_ok = want_dok && (sram_q.size() > 0 || allow_spur);
    rdata   = (sram_q.size() > 0) ? sram_q[0].inst : 32'($urandom);
    @(negedge clk);
    e_req = !reset && pc_req_valid && !flush &&
            (rdy_q.size() + wait_q.size() + cancel_m < DEPTH);
    e_vld = !reset && !flush && (rdy_q.size() > 0);
    chk("req",    64'(inst_sram_req), 64'(e_req));
    chk("ready",  64'(pc_req_ready), 64'(e_req && addr_ok));
    chk("addr",   64'(inst_sram_addr), 64'(pc_req_addr));
    chk("wr",     64'(inst_sram_wr), 64'(0));
    chk("size",   64'(inst_sram_size), 64'(2));
    chk("valid",  64'(if_to_id_valid), 64'(e_vld));
    if (e_vld) chk("head", {if_to_id_pc, if_to_id_inst}, {rdy_q[0].pc, rdy_q[0].inst});
    chk("alloc_cnt",  64'(dut.alloc_cnt_q), 64'(rdy_q.size() + wait_q.size()));
    chk("cancel_cnt", 64'(dut.cancel_cnt_q), 64'(cancel_m));
    last_req = inst_sram_req;
    last_vld = if_to_id_valid;
    last_pc  = if_to_id_pc;
    last_acc = e_req && addr_ok;
    if (if_to_id_valid && id_allow_in) begin
      dlog.push_back(if_to_id_pc);
      dcyc.push_back(cyc);
    end
    if (last_acc) acyc.push_back(cyc);
    if (reset) begin
      rdy_q.delete(); wait_q.delete(); sram_q.delete(); cancel_m = 0;
    end else begin
      if (data_ok && sram_q.size() > 0) void'(sram_q.pop_front());
      if (last_acc) sram_q.push_back({pc_req_addr, inst_of(pc_req_addr)});
      if (flush) begin
        if (data_ok) begin
          if (cancel_m > 0) cancel_m--;
          else if (wait_q.size() > 0) void'(wait_q.pop_front());
        end
        cancel_m += wait_q.size();
        wait_q.delete();
        rdy_q.delete();
      end else begin
        if (e_vld && id_allow_in) void'(rdy_q.pop_front());
        if (data_ok) begin
          if (cancel_m > 0) cancel_m--;
          else if (wait_q.size() > 0) begin
            e.pc   = wait_q.pop_front();
            e.inst = rdata;
            rdy_q.push_back(e);
          end
        end
        if (last_acc) wait_q.push_back(pc_req_addr);
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; pc_req_valid = 0; flush = 0; addr_ok = 0; want_dok = 0; id_allow_in = 0;
    for (int i = 0; i < n; i++) step();
    reset = 1'b0;
    dlog.delete(); dcyc.delete(); acyc.delete();
  endtask

  // Drive an in-order fetch stream of n pcs from base for up to cycles cycles.
  task automatic stream(input logic [31:0] base, input int n, input int cycles);
    int k = 0;
    for (int i = 0; i < cycles; i++) begin
      pc_req_valid = (k < n);
      pc_req_addr  = base + 32'(4 * k);
      step();
      if (last_acc) k++;
    end
    pc_req_valid = 0;
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset(2);
    chk("rst_alloc", 64'(dut.alloc_cnt_q), 64'(0));
    chk("rst_valid", 64'(if_to_id_valid), 64'(0));

    // Back-to-back fetch with a one-cycle SRAM.
    addr_ok = 1; want_dok = 1; id_allow_in = 1;
    stream(32'h1c00_0000, 3, 10);
    chk("t1_count", 64'(dlog.size()), 64'(3));
    if (dlog.size() == 3) begin
      chk("t1_pc0", 64'(dlog[0]), 64'(32'h1c00_0000));
      chk("t1_pc1", 64'(dlog[1]), 64'(32'h1c00_0004));
      chk("t1_pc2", 64'(dlog[2]), 64'(32'h1c00_0008));
      chk("t1_lat", 64'(dcyc[0] - acyc[0]), 64'(2));
      chk("t1_b2b", 64'(dcyc[2] - dcyc[0]), 64'(2));
    end

    // Fill to DEPTH with responses held off.
    do_reset(1);
    addr_ok = 1; want_dok = 0; id_allow_in = 0;
    stream(32'h1c00_0000, 8, 5);
    chk("t2_accepts", 64'(acyc.size()), 64'(4));
    chk("t2_req_full", 64'(last_req), 64'(0));
    want_dok = 1;
    for (int i = 0; i < 4; i++) step();
    want_dok = 0;
    step();
    chk("t2_valid", 64'(last_vld), 64'(1));
    chk("t2_pc", 64'(last_pc), 64'(32'h1c00_0000));

    // Flush with 3 in flight; late responses must be dropped.
    do_reset(1);
    addr_ok = 1; want_dok = 0; id_allow_in = 1;
    stream(32'h1c00_0000, 3, 3);
    flush = 1; step(); flush = 0;
    for (int i = 0; i < sram_q.size(); i++) sram_q[i].inst = 32'hdead_beef;
    chk("t3_cancel", 64'(dut.cancel_cnt_q), 64'(3));
    dlog.delete();
    want_dok = 1;
    stream(32'h1c00_0100, 1, 10);
    chk("t3_count", 64'(dlog.size()), 64'(1));
    if (dlog.size() > 0) chk("t3_pc", 64'(dlog[0]), 64'(32'h1c00_0100));

    // Flush coinciding with data_ok, 2 unfilled and one filled entry.
    do_reset(1);
    addr_ok = 1; want_dok = 0; id_allow_in = 0;
    stream(32'h1c00_0200, 3, 3);
    want_dok = 1; step();
    flush = 1; step(); flush = 0; want_dok = 0;
    chk("t4_vld_in_flush", 64'(last_vld), 64'(0));
    chk("t4_cancel", 64'(dut.cancel_cnt_q), 64'(1));
    want_dok = 1; step(); step(); want_dok = 0;

    // Alloc, fill and pop in one cycle; then pointer wrap.
    do_reset(1);
    addr_ok = 1; want_dok = 0; id_allow_in = 0;
    pc_req_valid = 1; pc_req_addr = 32'h1c00_0300; step();
    want_dok = 1; pc_req_addr = 32'h1c00_0304; step();
    id_allow_in = 1; pc_req_addr = 32'h1c00_0308; step();
    chk("t5_triple", 64'(last_acc && last_vld), 64'(1));
    chk("t5_alloc", 64'(dut.alloc_cnt_q), 64'(2));
    stream(32'h1c00_030c, 6, 14);
    chk("t5_count", 64'(dlog.size()), 64'(9));
    for (int i = 0; i < 9 && i < dlog.size(); i++)
      chk("t5_wrap_pc", 64'(dlog[i]), 64'(32'h1c00_0300 + 32'(4 * i)));

    // Reset in the middle of traffic with owed drops outstanding.
    do_reset(1);
    addr_ok = 1; want_dok = 0; id_allow_in = 0;
    stream(32'h1c00_0400, 1, 1);
    flush = 1; step(); flush = 0;
    stream(32'h1c00_0500, 2, 2);
    pc_req_valid = 1; reset = 1; step(); reset = 0; pc_req_valid = 0;
    chk("t6_req", 64'(last_req), 64'(0));
    chk("t6_alloc", 64'(dut.alloc_cnt_q), 64'(0));
    chk("t6_cancel", 64'(dut.cancel_cnt_q), 64'(0));
    chk("t6_valid", 64'(if_to_id_valid), 64'(0));

    // Randomized traffic.
    pc_req_addr = 32'h1c00_1000;
    for (int i = 0; i < 4000; i++) begin
      reset       = ($urandom_range(0, 299) == 0);
      pc_req_valid = ($urandom_range(0, 9) < 8);
      flush       = ($urandom_range(0, 29) == 0);
      addr_ok     = ($urandom_range(0, 9) < 7);
      want_dok    = ($urandom_range(0, 9) < 6);
      allow_spur  = ($urandom_range(0, 19) == 0);
      id_allow_in = ($urandom_range(0, 9) < 7);
      step();
      if (last_acc) pc_req_addr = {$urandom_range(0, 32'hffff), 16'h0} | (32'($urandom) & 32'hfffc);
    end
    reset = 0; flush = 0; allow_spur = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
